// File: rtl/param_reg_stack.sv
// Parameterised register stack: entry 0 is the top, with push/pop/replace/swap/dup/over ops.
// Ops that would underrun operands or overrun space are rejected and flagged in sticky errors.
module param_reg_stack #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [2:0]       stackOP,
   input  logic [WIDTH-1:0] w,
   input  logic             err_clr,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [2:0] OpNop    = 3'd0;
   localparam logic [2:0] OpPush   = 3'd1;
   localparam logic [2:0] OpPopRep = 3'd2;
   localparam logic [2:0] OpPop    = 3'd3;
   localparam logic [2:0] OpPop2   = 3'd4;
   localparam logic [2:0] OpSwap   = 3'd5;
   localparam logic [2:0] OpDup    = 3'd6;
   localparam logic [2:0] OpOver   = 3'd7;

   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   logic [WIDTH-1:0] stk_q [DEPTH];
   logic [WIDTH-1:0] stk_d [DEPTH];
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             need_space;
   logic [1:0]       need_ops;
   logic             lack_ops;
   logic             lack_space;
   logic [WIDTH-1:0] push_val;

   // Operand shortage is checked first so a full stack lacking operands reports underflow.
   always_comb begin
      need_space = 1'b0;
      need_ops   = 2'd0;
      case (stackOP)
         OpPush:                    need_space = 1'b1;
         OpPopRep, OpPop2, OpSwap:  need_ops   = 2'd2;
         OpPop:                     need_ops   = 2'd1;
         OpDup:   begin need_space = 1'b1; need_ops = 2'd1; end
         OpOver:  begin need_space = 1'b1; need_ops = 2'd2; end
         default: ;
      endcase
      lack_ops   = cnt_q < CW'(need_ops);
      lack_space = need_space && (cnt_q == DepthC);
   end

   always_comb begin
      stk_d    = stk_q;
      cnt_d    = cnt_q;
      push_val = w;
      if (stackOP == OpDup)  push_val = stk_q[0];
      if (stackOP == OpOver) push_val = stk_q[1];
      if (!lack_ops && !lack_space) begin
         case (stackOP)
            OpPush, OpDup, OpOver: begin
               for (int i = int'(DEPTH) - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
               stk_d[0] = push_val;
               cnt_d    = cnt_q + CW'(1);
            end
            OpPopRep: begin
               stk_d[0] = w;
               for (int i = 1; i < int'(DEPTH) - 1; i++) stk_d[i] = stk_q[i+1];
               stk_d[DEPTH-1] = '0;
               cnt_d          = cnt_q - CW'(1);
            end
            OpPop: begin
               for (int i = 0; i < int'(DEPTH) - 1; i++) stk_d[i] = stk_q[i+1];
               stk_d[DEPTH-1] = '0;
               cnt_d          = cnt_q - CW'(1);
            end
            OpPop2: begin
               for (int i = 0; i < int'(DEPTH) - 2; i++) stk_d[i] = stk_q[i+2];
               stk_d[DEPTH-2] = '0;
               stk_d[DEPTH-1] = '0;
               cnt_d          = cnt_q - CW'(2);
            end
            OpSwap: begin
               stk_d[0] = stk_q[1];
               stk_d[1] = stk_q[0];
            end
            default: ;
         endcase
      end
      // A flag set on this edge survives err_clr; the other flag is still cleared.
      ovf_d = (ovf_q & ~err_clr) | (lack_space & ~lack_ops);
      unf_d = (unf_q & ~err_clr) | lack_ops;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stk_q <= '{default: '0};
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         stk_q <= stk_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign a         = stk_q[0];
   assign b         = stk_q[1];
   assign c         = stk_q[2];
   assign count     = cnt_q;
   assign full      = (cnt_q == DepthC);
   assign empty     = (cnt_q == '0);
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_param_reg_stack.sv
// Bench for param_reg_stack: directed vector table, hand sequences for flags and async reset,
// and randomized ops against a queue-based model (default instance plus WIDTH=32/DEPTH=4).
module tb_param_reg_stack;

   logic        CLK;
   logic        rst1_n, rst2_n;
   logic [2:0]  op1, op2;
   logic [15:0] w1;
   logic [31:0] w2;
   logic        clr1, clr2;
   logic [15:0] a1, b1, c1;
   logic [31:0] a2, b2, c2;
   logic [3:0]  cnt1;
   logic [2:0]  cnt2;
   logic        full1, empty1, ovf1, unf1;
   logic        full2, empty2, ovf2, unf2;

   int checks = 0;
   int failures = 0;

   param_reg_stack dut1 (
      .CLK(CLK), .RST_N(rst1_n), .stackOP(op1), .w(w1), .err_clr(clr1),
      .a(a1), .b(b1), .c(c1), .count(cnt1), .full(full1), .empty(empty1),
      .overflow(ovf1), .underflow(unf1)
   );

   param_reg_stack #(.WIDTH(32), .DEPTH(4)) dut2 (
      .CLK(CLK), .RST_N(rst2_n), .stackOP(op2), .w(w2), .err_clr(clr2),
      .a(a2), .b(b2), .c(c2), .count(cnt2), .full(full2), .empty(empty2),
      .overflow(ovf2), .underflow(unf2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [2:0]  op;
      logic [15:0] w;
      logic        clr;
      logic [15:0] ea, eb, ec;
      int          cnt;
      logic        ovf, unf;
   } vec_t;

   vec_t vecs[19];

   // Behavioural model: element 0 of the queue is the top of stack.
   logic [15:0] mq[$];
   logic        m_ovf, m_unf;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic check1(input string tag, input logic [15:0] ea, eb, ec, input int ecnt,
                         input logic eovf, eunf);
      chk({tag, ".a"}, a1, ea);
      chk({tag, ".b"}, b1, eb);
      chk({tag, ".c"}, c1, ec);
      chk({tag, ".count"}, cnt1, ecnt);
      chk({tag, ".full"}, full1, ecnt == 8);
      chk({tag, ".empty"}, empty1, ecnt == 0);
      chk({tag, ".overflow"}, ovf1, eovf);
      chk({tag, ".underflow"}, unf1, eunf);
   endtask

   task automatic check2(input string tag, input logic [31:0] ea, eb, ec, input int ecnt,
                         input logic eovf, eunf);
      chk({tag, ".a"}, a2, ea);
      chk({tag, ".b"}, b2, eb);
      chk({tag, ".c"}, c2, ec);
      chk({tag, ".count"}, cnt2, ecnt);
      chk({tag, ".full"}, full2, ecnt == 4);
      chk({tag, ".empty"}, empty2, ecnt == 0);
      chk({tag, ".overflow"}, ovf2, eovf);
      chk({tag, ".underflow"}, unf2, eunf);
   endtask

   task automatic do1(input logic [2:0] op, input logic [15:0] wv, input logic clr);
      op1 = op; w1 = wv; clr1 = clr;
      @(posedge CLK); #1;
      op1 = 3'd0; clr1 = 1'b0;
   endtask

   task automatic do2(input logic [2:0] op, input logic [31:0] wv, input logic clr);
      op2 = op; w2 = wv; clr2 = clr;
      @(posedge CLK); #1;
      op2 = 3'd0; clr2 = 1'b0;
   endtask

   task automatic reset1();
      @(negedge CLK); rst1_n = 1'b0;
      @(negedge CLK); rst1_n = 1'b1;
      mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   // Operand and space needs follow the op list; operand shortage reports underflow first.
   task automatic model_op(input logic [2:0] op, input logic [15:0] wv, input logic clr);
      int n = mq.size();
      int need = 0;
      bit grows = (op == 3'd1 || op == 3'd6 || op == 3'd7);
      bit lo, ls;
      logic [15:0] t;
      if (op == 3'd3 || op == 3'd6) need = 1;
      if (op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd7) need = 2;
      lo = n < need;
      ls = grows && n == 8;
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (lo) m_unf = 1'b1;
      else if (ls) m_ovf = 1'b1;
      else begin
         case (op)
            3'd1: mq.push_front(wv);
            3'd2: begin mq.delete(1); mq[0] = wv; end
            3'd3: void'(mq.pop_front());
            3'd4: begin void'(mq.pop_front()); void'(mq.pop_front()); end
            3'd5: begin t = mq[0]; mq[0] = mq[1]; mq[1] = t; end
            3'd6: begin t = mq[0]; mq.push_front(t); end
            3'd7: begin t = mq[1]; mq.push_front(t); end
            default: ;
         endcase
      end
   endtask

   function automatic logic [15:0] mval(input int i);
      return (i < mq.size()) ? mq[i] : 16'h0;
   endfunction

   initial begin
      rst1_n = 1'b0; rst2_n = 1'b0;
      op1 = '0; op2 = '0; w1 = '0; w2 = '0; clr1 = 1'b0; clr2 = 1'b0;
      #1;
      check1("reset1", 0, 0, 0, 0, 0, 0);
      check2("reset2", 0, 0, 0, 0, 0, 0);
      @(negedge CLK); rst1_n = 1'b1; rst2_n = 1'b1;

      vecs[0]  = '{3'd1, 16'h1111, 1'b0, 16'h1111, 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, 16'h2222, 1'b0, 16'h2222, 16'h1111, 16'h0000, 2, 1'b0, 1'b0};
      vecs[2]  = '{3'd1, 16'h3333, 1'b0, 16'h3333, 16'h2222, 16'h1111, 3, 1'b0, 1'b0};
      vecs[3]  = '{3'd2, 16'h5555, 1'b0, 16'h5555, 16'h1111, 16'h0000, 2, 1'b0, 1'b0};
      vecs[4]  = '{3'd5, 16'h0000, 1'b0, 16'h1111, 16'h5555, 16'h0000, 2, 1'b0, 1'b0};
      vecs[5]  = '{3'd4, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
      vecs[6]  = '{3'd3, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
      vecs[7]  = '{3'd1, 16'hAAAA, 1'b0, 16'hAAAA, 16'h0000, 16'h0000, 1, 1'b0, 1'b1};
      vecs[8]  = '{3'd7, 16'h0000, 1'b0, 16'hAAAA, 16'h0000, 16'h0000, 1, 1'b0, 1'b1};
      vecs[9]  = '{3'd0, 16'h0000, 1'b1, 16'hAAAA, 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
      vecs[10] = '{3'd6, 16'h0000, 1'b0, 16'hAAAA, 16'hAAAA, 16'h0000, 2, 1'b0, 1'b0};
      vecs[11] = '{3'd7, 16'h0000, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 3, 1'b0, 1'b0};
      vecs[12] = '{3'd4, 16'h0000, 1'b0, 16'hAAAA, 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
      vecs[13] = '{3'd3, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
      vecs[14] = '{3'd3, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
      vecs[15] = '{3'd3, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
      vecs[16] = '{3'd1, 16'h0001, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1, 1'b0, 1'b0};
      vecs[17] = '{3'd5, 16'h0000, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1, 1'b0, 1'b1};
      vecs[18] = '{3'd0, 16'h0000, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1, 1'b0, 1'b1};

      for (int i = 0; i < 19; i++) begin
         do1(vecs[i].op, vecs[i].w, vecs[i].clr);
         check1($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].cnt,
                vecs[i].ovf, vecs[i].unf);
      end

      // Fill to full with underflow already set, overflow, then clear with a new overflow.
      reset1();
      do1(3'd3, 16'h0, 1'b0);
      check1("empty_pop", 0, 0, 0, 0, 0, 1);
      for (int i = 1; i <= 8; i++) do1(3'd1, 16'(i), 1'b0);
      check1("fill8", 8, 7, 6, 8, 0, 1);
      do1(3'd1, 16'h00FF, 1'b0);
      check1("push_full", 8, 7, 6, 8, 1, 1);
      do1(3'd6, 16'h0, 1'b1);
      check1("dup_full_clr", 8, 7, 6, 8, 1, 0);
      do1(3'd0, 16'h0, 1'b1);
      check1("clr_ovf", 8, 7, 6, 8, 0, 0);
      do1(3'd4, 16'h0, 1'b0);
      check1("pop2_full", 6, 5, 4, 6, 0, 0);

      // Asynchronous reset between edges while a push is being presented.
      reset1();
      do1(3'd1, 16'h1234, 1'b0);
      do1(3'd1, 16'h5678, 1'b0);
      op1 = 3'd1; w1 = 16'h7777;
      #2 rst1_n = 1'b0;
      #1 check1("async_rst1", 0, 0, 0, 0, 0, 0);
      @(posedge CLK); #1;
      check1("rst1_held", 0, 0, 0, 0, 0, 0);
      @(negedge CLK); rst1_n = 1'b1;
      @(posedge CLK); #1;
      op1 = 3'd0;
      check1("rst1_first_op", 16'h7777, 0, 0, 1, 0, 0);

      // Same on the wide, shallow instance, then its full/overflow boundary.
      do2(3'd1, 32'hDEADBEEF, 1'b0);
      do2(3'd1, 32'h12345678, 1'b0);
      check2("w32_push2", 32'h12345678, 32'hDEADBEEF, 0, 2, 0, 0);
      op2 = 3'd1; w2 = 32'hCAFEF00D;
      #2 rst2_n = 1'b0;
      #1 check2("async_rst2", 0, 0, 0, 0, 0, 0);
      @(negedge CLK); rst2_n = 1'b1;
      @(posedge CLK); #1;
      op2 = 3'd0;
      check2("rst2_first_op", 32'hCAFEF00D, 0, 0, 1, 0, 0);
      do2(3'd1, 32'h1, 1'b0);
      do2(3'd1, 32'h2, 1'b0);
      do2(3'd1, 32'h3, 1'b0);
      check2("w32_full", 32'h3, 32'h2, 32'h1, 4, 0, 0);
      do2(3'd7, 32'h9, 1'b0);
      check2("w32_over_full", 32'h3, 32'h2, 32'h1, 4, 1, 0);
      do2(3'd4, 32'h0, 1'b0);
      check2("w32_pop2", 32'h1, 32'hCAFEF00D, 0, 2, 1, 0);
      do2(3'd2, 32'hFFFF0000, 1'b1);
      check2("w32_poprep", 32'hFFFF0000, 0, 0, 1, 0, 0);

      // Randomized ops against the model; first half biased toward pushes to reach full.
      reset1();
      for (int i = 0; i < 600; i++) begin
         logic [2:0]  rop;
         logic [15:0] rw;
         logic        rclr;
         rop  = 3'($urandom_range(0, 7));
         if (i < 300 && $urandom_range(0, 2) == 0) rop = 3'd1;
         rw   = 16'($urandom);
         rclr = ($urandom_range(0, 7) == 0);
         do1(rop, rw, rclr);
         model_op(rop, rw, rclr);
         check1($sformatf("rand%0d_op%0d", i, rop), mval(0), mval(1), mval(2), mq.size(),
                m_ovf, m_unf);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_reg_stack.md
PARAM_REG_STACK -- requirements
Module: param_reg_stack

Interface
REQ-001 Parameter WIDTH, default 16, data width of every stack entry; legal range 1..64.
REQ-002 Parameter DEPTH, default 8, number of stack entries; legal range 4..64.
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 stackOP  input  3  operation code, sampled each rising edge.
REQ-007 w  input  WIDTH  write data for push and pop-and-replace.
REQ-008 err_clr  input  1  synchronous clear of sticky error flags.
REQ-009 a  output  WIDTH  entry 0 (top of stack).
REQ-010 b  output  WIDTH  entry 1.
REQ-011 c  output  WIDTH  entry 2.
REQ-012 count  output  CW  number of valid entries, 0..DEPTH.
REQ-013 full  output  1  high when count == DEPTH.
REQ-014 empty  output  1  high when count == 0.
REQ-015 overflow  output  1  sticky: an op was rejected for lack of free space.
REQ-016 underflow  output  1  sticky: an op was rejected for lack of operands.

Function
REQ-017 a/b/c/full/empty are combinational from stored state, so an op sampled at edge N is visible after edge N, with 1-cycle latency.
REQ-018 Op 0, nop: no state change.
REQ-019 Op 1, push: entries shift down by one, entry 0 = w, count+1; requires count < DEPTH.
REQ-020 Op 2, pop-and-replace: entry 0 = w, entries 2..DEPTH-1 shift up to 1..DEPTH-2, last entry = 0, count-1; requires count >= 2.
REQ-021 Op 3, pop: entries shift up by one, last entry = 0, count-1; requires count >= 1.
REQ-022 Op 4, pop2: entries shift up by two, last two entries = 0, count-2; requires count >= 2.
REQ-023 Op 5, swap: exchange entries 0 and 1, count unchanged; requires count >= 2.
REQ-024 Op 6, dup: push a copy of entry 0, count+1; requires 1 <= count < DEPTH.
REQ-025 Op 7, over: push a copy of entry 1, count+1; requires 2 <= count < DEPTH.
REQ-026 An op failing its count requirement leaves all entries and count unchanged.
REQ-027 A rejected op sets overflow if the space requirement failed; otherwise it sets underflow.
REQ-028 dup or over on a full stack that also lacks operands sets underflow only.
REQ-029 Vacated entries always read 0; entries at index >= count are 0 at all times.
REQ-030 err_clr high clears both flags at the edge, unless the same edge sets a flag; set wins, and only the newly set flag survives.
REQ-031 count never wraps; it saturates by rejection at 0 and DEPTH.
REQ-032 Result values are unsigned bit copies; no arithmetic is performed inside the block.

Reset
REQ-033 RST_N low immediately (asynchronously) forces all entries to 0, count to 0, overflow and underflow to 0; hence a=b=c=0, empty=1, full=0.
REQ-034 Reset asserted mid-operation discards the in-flight op; the first op after RST_N rises is processed from the reset state.
REQ-035 RST_N deassertion is synchronised externally; the block needs no internal reset-release logic.

Verification
REQ-036 Reset, then push 0x1111, 0x2222, 0x3333 -> a=0x3333, b=0x2222, c=0x1111, count=3.
REQ-037 From REQ-036 state, op 2 with w=0x5555 -> a=0x5555, b=0x1111, c=0, count=2; then swap -> a=0x1111, b=0x5555.
REQ-038 DEPTH=8: push 8 values -> full=1; a 9th push -> contents unchanged, count=8, overflow=1; err_clr -> overflow=0.
REQ-039 Empty stack: pop -> underflow=1, count=0; one push then over -> underflow=1, count=1; err_clr with a simultaneous rejected pop -> underflow stays 1.
REQ-040 Push 0xAAAA, dup, over -> a=0xAAAA, b=0xAAAA, c=0xAAAA, count=3; pop2 -> a=0xAAAA, b=0, count=1.
REQ-041 Assert RST_N low between clock edges during a push sequence -> outputs go to reset values before the next edge; the bench repeats this with WIDTH=32, DEPTH=4.
